ped_crossing_ctrl: RTL and testbench

Pedestrian crossing controller that sits directly downstream of the vehicle traffic-light FSM. It consumes the 3-bit R-Y-G code, latches pedestrian push-button requests, and grants a WALK phase only inside a vehicle red. The WALK phase is followed by a flashing, counted-down clearance phase. It also aborts safely if red ends early, and flags illegal light codes.

---
 rtl/ped_crossing_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller. Watches the vehicle R-Y-G code, latches
// push-button requests and grants WALK only inside a vehicle red. WALK is
// followed by a flashing countdown clearance. If red ends early the crossing
// aborts to IDLE. A non-one-hot light code parks the block in FAULT.
module ped_crossing_ctrl #(
    parameter int WALK_CYCLES  = 8,
    parameter int CLEAR_CYCLES = 6,
    parameter int FLASH_DIV    = 2,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       rgy,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             flash,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pending,
    output logic             abort,
    output logic             fault
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WALK  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // The flash phase counter runs 0..FLASH_DIV-1.
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    localparam logic [2:0]       RED        = 3'b100;
    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [FW-1:0]    FLASH_LOAD = FW'(FLASH_DIV - 1);
    localparam logic [FW-1:0]    FLASH_ONE  = FW'(1);
    localparam logic [FW-1:0]    FLASH_ZERO = FW'(0);

    // A light code is legal only when exactly one lamp is lit.
    function automatic logic is_legal(input logic [2:0] code);
        return (code == 3'b100) || (code == 3'b010) || (code == 3'b001);
    endfunction

    state_t           state_r;
    logic [2:0]       prev_rgy_r;
    logic [CNT_W-1:0] walk_cnt_r;
    logic [FW-1:0]    flash_cnt_r;
    logic             legal_s;
    logic             red_entry_s;

    assign legal_s     = is_legal(rgy);
    assign red_entry_s = (rgy == RED) && (prev_rgy_r != RED);

    // Crossing FSM with all lamp/status outputs registered alongside state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            prev_rgy_r  <= RED;
            walk_cnt_r  <= CNT_ZERO;
            flash_cnt_r <= FLASH_ZERO;
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
            flash       <= 1'b0;
            countdown   <= CNT_ZERO;
            req_pending <= 1'b0;
            abort       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            prev_rgy_r <= rgy;
            abort      <= 1'b0;
            if (!legal_s) begin
                // Illegal code overrides everything, including pending requests.
                state_r     <= ST_FAULT;
                walk        <= 1'b0;
                dont_walk   <= 1'b1;
                flash       <= 1'b0;
                countdown   <= CNT_ZERO;
                req_pending <= 1'b0;
                fault       <= 1'b1;
            end else if (((state_r == ST_WALK) || (state_r == ST_CLEAR)) && (rgy != RED)) begin
                // Red ended under a crossing: drop to IDLE lamps at once.
                state_r   <= ST_IDLE;
                walk      <= 1'b0;
                dont_walk <= 1'b1;
                flash     <= 1'b0;
                countdown <= CNT_ZERO;
                abort     <= 1'b1;
                if ((state_r == ST_CLEAR) && ped_btn) begin
                    req_pending <= 1'b1;
                end else begin
                    req_pending <= req_pending;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (red_entry_s && (req_pending || ped_btn)) begin
                            state_r     <= ST_WALK;
                            walk        <= 1'b1;
                            dont_walk   <= 1'b0;
                            walk_cnt_r  <= WALK_LOAD;
                            req_pending <= 1'b0;
                        end else if (ped_btn) begin
                            req_pending <= 1'b1;
                        end else begin
                            req_pending <= req_pending;
                        end
                    end
                    ST_WALK: begin
                        if (walk_cnt_r == CNT_ONE) begin
                            state_r     <= ST_CLEAR;
                            walk        <= 1'b0;
                            dont_walk   <= 1'b1;
                            flash       <= 1'b1;
                            countdown   <= CLEAR_LOAD;
                            flash_cnt_r <= FLASH_LOAD;
                        end else begin
                            walk_cnt_r <= walk_cnt_r - CNT_ONE;
                        end
                    end
                    ST_CLEAR: begin
                        if (ped_btn) begin
                            req_pending <= 1'b1;
                        end else begin
                            req_pending <= req_pending;
                        end
                        if (countdown == CNT_ONE) begin
                            state_r   <= ST_IDLE;
                            flash     <= 1'b0;
                            dont_walk <= 1'b1;
                            countdown <= CNT_ZERO;
                        end else begin
                            countdown <= countdown - CNT_ONE;
                            if (flash_cnt_r == FLASH_ZERO) begin
                                dont_walk   <= ~dont_walk;
                                flash_cnt_r <= FLASH_LOAD;
                            end else begin
                                flash_cnt_r <= flash_cnt_r - FLASH_ONE;
                            end
                        end
                    end
                    ST_FAULT: begin
                        // Leaving FAULT is never a red entry; prev_rgy handles the next edge.
                        state_r <= ST_IDLE;
                        fault   <= 1'b0;
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                        flash     <= 1'b0;
                        countdown <= CNT_ZERO;
                        fault     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Self-checking bench for ped_crossing_ctrl: directed scenarios followed by
// randomized light/button traffic, all compared against a phase/elapsed-time
// reference model.
module tb_ped_crossing_ctrl;

    localparam int W   = 8;
    localparam int C   = 6;
    localparam int DIV = 2;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    rgy = 3'b001;
    logic          ped_btn = 1'b0;
    logic          walk, dont_walk, flash, req_pending, abort, fault;
    logic [CW-1:0] countdown;

    int checks = 0;
    int failures = 0;

    // Reference model state: phase 0 idle, 1 walk, 2 clear, 3 fault; t = edges since phase entry.
    int       m_ph;
    int       m_t;
    bit       m_req;
    bit       m_abort;
    bit [2:0] m_prev;

    ped_crossing_ctrl #(
        .WALK_CYCLES(W), .CLEAR_CYCLES(C), .FLASH_DIV(DIV), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rgy(rgy), .ped_btn(ped_btn),
        .walk(walk), .dont_walk(dont_walk), .flash(flash),
        .countdown(countdown), .req_pending(req_pending),
        .abort(abort), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_t = 0; m_req = 0; m_abort = 0; m_prev = 3'b100;
    endtask

    task automatic model_step(input bit [2:0] r, input bit b);
        bit legal;
        bit entry;
        legal = ($countones(r) == 1);
        entry = (r == 3'b100) && (m_prev != 3'b100);
        m_abort = 0;
        if (!legal) begin
            m_ph = 3; m_req = 0;
        end else if ((m_ph == 1 || m_ph == 2) && r != 3'b100) begin
            if (m_ph == 2 && b) m_req = 1;
            m_ph = 0; m_abort = 1;
        end else begin
            case (m_ph)
                0: begin
                    if (entry && (m_req || b)) begin
                        m_ph = 1; m_t = 0; m_req = 0;
                    end else if (b) m_req = 1;
                end
                1: begin
                    m_t++;
                    if (m_t == W) begin m_ph = 2; m_t = 0; end
                end
                2: begin
                    if (b) m_req = 1;
                    m_t++;
                    if (m_t == C) m_ph = 0;
                end
                default: m_ph = 0;
            endcase
        end
        m_prev = r;
    endtask

    task automatic check_all(input string tag);
        bit e_dw;
        int e_cd;
        e_dw = (m_ph == 2) ? (((m_t / DIV) % 2) == 0) : (m_ph != 1);
        e_cd = (m_ph == 2) ? (C - m_t) : 0;
        chk({tag, ".walk"}, {7'd0, walk}, {7'd0, m_ph == 1});
        chk({tag, ".dont_walk"}, {7'd0, dont_walk}, {7'd0, e_dw});
        chk({tag, ".flash"}, {7'd0, flash}, {7'd0, m_ph == 2});
        chk({tag, ".countdown"}, {4'd0, countdown}, 8'(e_cd));
        chk({tag, ".req_pending"}, {7'd0, req_pending}, {7'd0, m_req});
        chk({tag, ".abort"}, {7'd0, abort}, {7'd0, m_abort});
        chk({tag, ".fault"}, {7'd0, fault}, {7'd0, m_ph == 3});
        chk({tag, ".lamp_excl"}, {7'd0, walk & dont_walk}, 8'd0);
    endtask

    task automatic do_cycle(input string tag, input bit [2:0] r, input bit b);
        @(negedge clk);
        rgy = r;
        ped_btn = b;
        @(posedge clk);
        model_step(r, b);
        #1;
        check_all(tag);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".walk"}, {7'd0, walk}, 8'd0);
        chk({tag, ".dont_walk"}, {7'd0, dont_walk}, 8'd1);
        chk({tag, ".flash"}, {7'd0, flash}, 8'd0);
        chk({tag, ".countdown"}, {4'd0, countdown}, 8'd0);
        chk({tag, ".req_pending"}, {7'd0, req_pending}, 8'd0);
        chk({tag, ".abort"}, {7'd0, abort}, 8'd0);
        chk({tag, ".fault"}, {7'd0, fault}, 8'd0);
    endtask

    initial begin
        int exp_cd[6];
        int exp_dw[6];
        bit [2:0] cur;
        bit [2:0] bad[5];
        exp_cd = '{6, 5, 4, 3, 2, 1};
        exp_dw = '{1, 1, 0, 0, 1, 1};
        bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

        // Reset and check reset state.
        model_reset();
        #23;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plan 1: press during green, red entry gives full WALK then CLEAR.
        do_cycle("green", 3'b001, 1'b0);
        do_cycle("press_green", 3'b001, 1'b1);
        chk("req_latched", {7'd0, req_pending}, 8'd1);
        do_cycle("green_wait", 3'b001, 1'b0);
        chk("req_held", {7'd0, req_pending}, 8'd1);
        for (int i = 0; i < W; i++) begin
            do_cycle("walk_seq", 3'b100, 1'b0);
            chk("walk_on", {7'd0, walk}, 8'd1);
            chk("req_clr_walk", {7'd0, req_pending}, 8'd0);
        end
        for (int i = 0; i < C; i++) begin
            do_cycle("clear_seq", 3'b100, 1'b0);
            chk("clear_cd", {4'd0, countdown}, 8'(exp_cd[i]));
            chk("clear_dw", {7'd0, dont_walk}, 8'(exp_dw[i]));
            chk("clear_flash", {7'd0, flash}, 8'd1);
        end
        do_cycle("clear_done", 3'b100, 1'b0);
        chk("idle_cd0", {4'd0, countdown}, 8'd0);
        chk("idle_flash0", {7'd0, flash}, 8'd0);

        // Plan 2: press on the same edge as yellow->red entry.
        do_cycle("yellow", 3'b010, 1'b0);
        do_cycle("same_edge", 3'b100, 1'b1);
        chk("same_edge_walk", {7'd0, walk}, 8'd1);
        chk("same_edge_req", {7'd0, req_pending}, 8'd0);
        // Plan 3: abort after 3 WALK cycles.
        do_cycle("walk2", 3'b100, 1'b0);
        do_cycle("walk3", 3'b100, 1'b0);
        do_cycle("abort_walk", 3'b010, 1'b0);
        chk("abort_pulse", {7'd0, abort}, 8'd1);
        do_cycle("abort_gone", 3'b010, 1'b0);
        chk("abort_one_cycle", {7'd0, abort}, 8'd0);

        // Press during CLEAR then abort: request survives.
        do_cycle("g", 3'b001, 1'b1);
        for (int i = 0; i < W + 2; i++) do_cycle("to_clear", 3'b100, 1'b0);
        do_cycle("press_clear", 3'b100, 1'b1);
        do_cycle("abort_clear", 3'b001, 1'b0);
        chk("req_after_abort", {7'd0, req_pending}, 8'd1);

        // Plan 4: illegal code in CLEAR, then red does not start WALK.
        for (int i = 0; i < W + 2; i++) do_cycle("to_clear2", 3'b100, 1'b0);
        do_cycle("press_clear2", 3'b100, 1'b1);
        do_cycle("illegal", 3'b110, 1'b0);
        chk("fault_on", {7'd0, fault}, 8'd1);
        chk("fault_req_clr", {7'd0, req_pending}, 8'd0);
        do_cycle("fault_exit_red", 3'b100, 1'b1);
        chk("fault_exit_nowalk", {7'd0, walk}, 8'd0);
        do_cycle("red_press", 3'b100, 1'b1);
        chk("red_press_nowalk", {7'd0, walk}, 8'd0);
        do_cycle("green2", 3'b001, 1'b1);
        do_cycle("reentry", 3'b100, 1'b0);
        chk("reentry_walk", {7'd0, walk}, 8'd1);

        // Plan 6: async reset mid-WALK, between edges.
        do_cycle("walk_mid", 3'b100, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        #1;
        rst_n = 1'b1;

        // Plan 5: red held through reset release, press -> no WALK until re-entry.
        do_cycle("held_red", 3'b100, 1'b1);
        chk("held_red_nowalk", {7'd0, walk}, 8'd0);
        do_cycle("held_red2", 3'b100, 1'b0);
        do_cycle("exit_red", 3'b010, 1'b0);
        do_cycle("reenter_red", 3'b100, 1'b0);
        chk("held_reentry_walk", {7'd0, walk}, 8'd1);

        // Randomized traffic against the model.
        cur = 3'b100;
        for (int n = 0; n < 3000; n++) begin
            int r;
            bit [2:0] code;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                code = bad[$urandom_range(0, 4)];
            end else begin
                if (r < 12) begin
                    case ($urandom_range(0, 2))
                        0: cur = 3'b100;
                        1: cur = 3'b010;
                        default: cur = 3'b001;
                    endcase
                end
                code = cur;
            end
            do_cycle("rand", code, $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
